// File: rtl/fft_ram_arbiter.sv
// Round-robin arbiter sharing the single-port FFT sample/result RAM between the HPS master (A) and the FFT sequencer (B).
// Optional build macro FFT_RAM_ARB_FIXED_PRIO_EN: A always wins conflicts and no last-winner pointer is kept.
module fft_ram_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [BE_W-1:0]   a_byteenable,
    input  logic [DATA_W-1:0] a_writedata,
    output logic              a_waitrequest,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic [DATA_W-1:0] b_writedata,
    output logic              b_waitrequest,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,
    input  logic              b_lock,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    logic  a_req_c;
    logic  b_req_c;
    logic  lock_c;
    logic  grant_a_c;
    logic  grant_b_c;

    logic  rd_pending_q;
    logic  rd_pending_d;
    port_e rd_tag_q;
    port_e rd_tag_d;
    // Set when B won the most recent accepted access; lock only holds while this is true.
    logic  b_held_q;
    logic  b_held_d;

`ifndef FFT_RAM_ARB_FIXED_PRIO_EN
    port_e last_q;
    port_e last_d;
`endif

    assign a_req_c = a_read | a_write;
    assign b_req_c = b_read | b_write;
    assign lock_c  = b_lock & b_held_q;

    // Grant decision: lock first, then conflict resolution, then single requester.
    always_comb begin
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        if (lock_c) begin
            grant_b_c = b_req_c;
        end else if (a_req_c && b_req_c) begin
`ifdef FFT_RAM_ARB_FIXED_PRIO_EN
            grant_a_c = 1'b1;
`else
            if (last_q == PORT_B) begin
                grant_a_c = 1'b1;
            end else begin
                grant_b_c = 1'b1;
            end
`endif
        end else begin
            grant_a_c = a_req_c;
            grant_b_c = b_req_c;
        end
    end

    assign a_waitrequest = a_req_c & ~grant_a_c;
    assign b_waitrequest = b_req_c & ~grant_b_c;

    // RAM port mux; address and data default to A when nobody is granted.
    always_comb begin
        ram_address    = a_address;
        ram_byteenable = a_byteenable;
        ram_writedata  = a_writedata;
        ram_write      = 1'b0;
        if (grant_b_c) begin
            ram_address    = b_address;
            ram_byteenable = b_byteenable;
            ram_writedata  = b_writedata;
            ram_write      = b_write;
        end else if (grant_a_c) begin
            ram_write = a_write;
        end
    end

    assign ram_chipselect = grant_a_c | grant_b_c;
    assign ram_clken      = 1'b1;

    // Next-state for read tracking, lock ownership and round-robin pointer.
    always_comb begin
        rd_pending_d = 1'b0;
        rd_tag_d     = rd_tag_q;
        b_held_d     = b_held_q;
`ifndef FFT_RAM_ARB_FIXED_PRIO_EN
        last_d       = last_q;
`endif
        if (grant_a_c) begin
            rd_pending_d = a_read & ~a_write;
            rd_tag_d     = PORT_A;
            b_held_d     = 1'b0;
`ifndef FFT_RAM_ARB_FIXED_PRIO_EN
            last_d       = PORT_A;
`endif
        end else if (grant_b_c) begin
            rd_pending_d = b_read & ~b_write;
            rd_tag_d     = PORT_B;
            b_held_d     = 1'b1;
`ifndef FFT_RAM_ARB_FIXED_PRIO_EN
            last_d       = PORT_B;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending_q <= 1'b0;
            rd_tag_q     <= PORT_A;
            b_held_q     <= 1'b0;
`ifndef FFT_RAM_ARB_FIXED_PRIO_EN
            last_q       <= PORT_B;
`endif
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_tag_q     <= rd_tag_d;
            b_held_q     <= b_held_d;
`ifndef FFT_RAM_ARB_FIXED_PRIO_EN
            last_q       <= last_d;
`endif
        end
    end

    // Read data is broadcast; only the valid strobe is steered to the owner.
    assign a_readdata      = ram_readdata;
    assign b_readdata      = ram_readdata;
    assign a_readdatavalid = rd_pending_q & (rd_tag_q == PORT_A);
    assign b_readdatavalid = rd_pending_q & (rd_tag_q == PORT_B);

endmodule

// File: doc/fft_ram_arbiter.md
# fft_ram_arbiter

Two-port arbiter that shares the single-port 1024x32 FFT sample/result RAM between the HPS-side Avalon-MM master (port A) and the FFT engine's sequencer (port B). It issues at most one RAM access per cycle and selects the winner by round-robin. It tracks outstanding reads so each requester receives a `readdatavalid` pulse only for its own reads. Port B can lock the RAM for contiguous butterfly sweeps.

## Interface
Parameters:
- `ADDR_W`, 10, word address width (1024 words)
- `DATA_W`, 32, data width
- `BE_W`, 4, byteenable width (`DATA_W/8`)

Ports:
- `clk`  in  1  single clock for the arbiter and the RAM
- `reset_n`  in  1  asynchronous, active-low reset
- `a_address` / `b_address`  in  ADDR_W  word address
- `a_read` / `b_read`  in  1  read request, held until accepted
- `a_write` / `b_write`  in  1  write request, held until accepted
- `a_byteenable` / `b_byteenable`  in  BE_W  write byte lanes
- `a_writedata` / `b_writedata`  in  DATA_W  write data
- `a_waitrequest` / `b_waitrequest`  out  1  request not accepted this cycle
- `a_readdata` / `b_readdata`  out  DATA_W  read data (driven from `ram_readdata`)
- `a_readdatavalid` / `b_readdatavalid`  out  1  read data valid for this port
- `b_lock`  in  1  hold the grant on B while it is high
- `ram_address`  out  ADDR_W  to RAM
- `ram_byteenable`  out  BE_W  to RAM
- `ram_chipselect`  out  1  to RAM; high in any cycle with an access
- `ram_write`  out  1  to RAM
- `ram_writedata`  out  DATA_W  to RAM
- `ram_clken`  out  1  RAM clock enable; constant 1
- `ram_readdata`  in  DATA_W  from RAM; valid one cycle after the read address

## Operation
- A port's request is `x_read | x_write`. A request is accepted in the cycle where it is high and `x_waitrequest` is 0.
- Grant is combinational from the current requests and the registered `last` pointer:
  - Only one port requesting: that port wins.
  - Both requesting: the port that is not `last` wins.
- `last` updates to the winner on every accepted access. Reset value is B, so A wins the first conflict.
- Lock: if `b_lock` is high and B won the previous accepted cycle, B keeps priority.
  - A waits, even when B is idle that cycle.
  - The lock releases in the cycle `b_lock` falls.
- The losing port sees `waitrequest` = 1. The winning port sees 0. An idle port sees 0, which has no effect.
- RAM signals are muxed combinationally from the winner. With no winner, `ram_chipselect` = 0, `ram_write` = 0, and the address holds the A value.
- Writes complete in the accept cycle and produce no response.
- Reads: the accept cycle registers `rd_pending` = 1 and `rd_tag` = winner. In the next cycle the matching `x_readdatavalid` = 1.
- `a_readdata` and `b_readdata` both carry `ram_readdata` unconditionally. Only `readdatavalid` is steered.
- `read` and `write` high together on one port: handled as a write, and no `readdatavalid` is produced.

## Timing
- Reset values:
  - `a_readdatavalid` = `b_readdatavalid` = 0
  - `rd_pending` = 0
  - `last` = B
  - lock state cleared
  - `ram_clken` = 1
- Read latency is 1 cycle: accepted in cycle N, `readdatavalid` and data in cycle N+1.
- Back-to-back reads are supported, one per cycle. Throughput is 1 access per cycle in total across both ports.
- Conflict latency: without lock, a waiting port is granted within 1 cycle. With lock, it waits until `b_lock` deasserts.
- Read-after-write to the same address by either port in consecutive cycles returns the new data. Same-cycle read-during-write cannot occur because there is a single access per cycle.
- Reset asserted mid-operation clears any pending `readdatavalid` immediately, and the read is dropped. Requesters must reissue the read after reset.
- The requester side has no combinational path from `waitrequest` to request. `waitrequest` depends only on the requests, `b_lock` and registered state.

## Configuration
- `FFT_RAM_ARB_FIXED_PRIO_EN`:
  - Defined: port A always wins conflicts, and the `last` pointer is not implemented. `b_lock` still overrides A while B holds the grant.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Single-port traffic: A writes `0xDEADBEEF` to address 5 with byteenable `0xF`, then reads address 5 → `a_waitrequest` = 0 throughout, and `a_readdatavalid` is high one cycle after the read accept with data `0xDEADBEEF`. `b_readdatavalid` stays 0.
- Conflict round-robin: after reset, A and B both read continuously → grants alternate A,B,A,B. Each port gets `readdatavalid` only on its own cycles, and `waitrequest` alternates.
- Byte lanes: B writes `0x11223344` to address 1023, then A writes `0xAA000000` to address 1023 with byteenable `0x8`; B reads address 1023 → `0xAA223344`. Address 1023 is the top address and must not alias to 0.
- Lock: B asserts `b_lock` and issues reads to addresses 0–7 while A requests continuously → A waits all 8 cycles. A is granted in the cycle `b_lock` drops.
- Reset mid-read: a read is accepted, then `reset_n` is pulled low before the next edge → no `readdatavalid` is produced, and `last` = B, so A wins the first conflict after reset.
- With `FFT_RAM_ARB_FIXED_PRIO_EN` defined: A and B both request for 4 cycles → A wins all 4 and B is stalled, with B granted on the first cycle A idles.
